// File: rtl/converter_tx_scheduler_pkg.sv
// Shared definitions for the serial transmitter scheduler: FSM encoding,
// default word width and helpers that size indices and counters.
package converter_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    // Bits needed to count down a full default-width frame (WIDTH-1 .. 0).
    localparam int CNT_W = $clog2(DEFAULT_WIDTH);

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One counter serves both the frame and the guard gap, so it must hold
    // the larger of WIDTH-1 and GAP-1.
    function automatic int cnt_width(input int width, input int gap);
        int w;
        w = (width > 1) ? $clog2(width) : 1;
        if (gap > 1 && $clog2(gap) > w) begin
            w = $clog2(gap);
        end
        return w;
    endfunction

endpackage

// File: rtl/converter_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request bit
// searching upward from ptr+1 with wraparound. The pointer is owned by the
// caller so the same arbiter can serve other multi-client blocks.
module rr_arbiter
    import converter_tx_scheduler_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] index_o,
    output logic          any_o
);

    // Walk candidates from farthest to nearest so the nearest set bit wins.
    always_comb begin
        int cand;
        cand    = 0;
        gnt_o   = '0;
        index_o = '0;
        any_o   = 1'b0;
        for (int k = N; k >= 1; k--) begin
            cand = (int'(ptr_i) + k) % N;
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                index_o     = IW'(cand);
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/converter_tx_scheduler.sv
// Shares one parallel-to-serial transmitter among N requesters: round-robin
// pick in IDLE, one-cycle LOAD strobe, WIDTH-cycle SHIFT window, then an
// optional guard gap before the next pick. All outputs are registered.
module converter_tx_scheduler
    import converter_tx_scheduler_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GAP   = 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [N-1:0]              REQ,
    input  logic [N*WIDTH-1:0]        DATA,
    output logic [N-1:0]              GRANT,
    output logic                      S_START,
    output logic [WIDTH-1:0]          P_IN,
    output logic                      BUSY,
    output logic [idx_width(N)-1:0]   CUR_ID,
    output logic                      FRAME_DONE
);

    localparam int IW = idx_width(N);
    localparam int CW = cnt_width(WIDTH, GAP);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    cur_id_q;
    logic [WIDTH-1:0] p_in_q;
    logic [N-1:0]     grant_q;
    logic             s_start_q;
    logic             busy_q;
    logic             frame_done_q;

    logic [N-1:0]     arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic [WIDTH-1:0] p_in_d;

    logic [WIDTH-1:0] data_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign data_arr[gi] = DATA[gi*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_arb (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .index_o (arb_idx),
        .any_o   (arb_any)
    );

    assign p_in_d = data_arr[arb_idx];

    // Scheduler FSM with registered strobes; REQ is only looked at in IDLE,
    // so request changes during a frame wait for the next pick.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ptr_q        <= IW'(N - 1);
            cur_id_q     <= '0;
            p_in_q       <= '0;
            grant_q      <= '0;
            s_start_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            grant_q      <= '0;
            s_start_q    <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        p_in_q    <= p_in_d;
                        cur_id_q  <= arb_idx;
                        ptr_q     <= arb_idx;
                        grant_q   <= arb_gnt;
                        s_start_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= CW'(WIDTH - 1);
                    state_q <= ST_SHIFT;
                    // A one-bit frame has its only SHIFT cycle right away.
                    if (WIDTH == 1) begin
                        frame_done_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q - CW'(1);
                    // Raise FRAME_DONE for the cycle in which the count reads 0.
                    if (cnt_q == CW'(1)) begin
                        frame_done_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        if (GAP == 0) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= CW'(GAP - 1);
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign GRANT      = grant_q;
    assign S_START    = s_start_q;
    assign P_IN       = p_in_q;
    assign BUSY       = busy_q;
    assign CUR_ID     = cur_id_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_converter_tx_scheduler.sv
// Scoreboard bench for converter_tx_scheduler: stimulus pushes expected
// grants, a negedge monitor pops and compares on every S_START.
module tb_converter_tx_scheduler;

    localparam int N = 4;
    localparam int W = 32;

    logic           CLK   = 1'b0;
    logic           RESET = 1'b0;
    logic [N-1:0]   REQ   = '0;
    logic [N-1:0]   REQ2  = '0;
    logic [N*W-1:0] DATA  = '0;
    logic [N*W-1:0] DATA2 = '0;

    logic [N-1:0] GRANT, GRANT2;
    logic         S_START, S_START2;
    logic [W-1:0] P_IN, P_IN2;
    logic         BUSY, BUSY2;
    logic [1:0]   CUR_ID, CUR_ID2;
    logic         FRAME_DONE, FRAME_DONE2;

    always #5 CLK = ~CLK;

    converter_tx_scheduler #(.N(N), .WIDTH(W), .GAP(2)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .DATA(DATA),
        .GRANT(GRANT), .S_START(S_START), .P_IN(P_IN), .BUSY(BUSY),
        .CUR_ID(CUR_ID), .FRAME_DONE(FRAME_DONE)
    );

    converter_tx_scheduler #(.N(N), .WIDTH(W), .GAP(0)) dut_gap0 (
        .CLK(CLK), .RESET(RESET), .REQ(REQ2), .DATA(DATA2),
        .GRANT(GRANT2), .S_START(S_START2), .P_IN(P_IN2), .BUSY(BUSY2),
        .CUR_ID(CUR_ID2), .FRAME_DONE(FRAME_DONE2)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           abs_cyc;   // required S_START cycle, -1 = unchecked
        int           spacing;   // required distance to previous start, -1 = unchecked
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_start = -1;
    int   fd_seen = 0;
    int   fd_exp  = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Main scoreboard monitor for the GAP=2 instance.
    always @(negedge CLK) begin
        exp_t e;
        if (RESET && S_START) begin
            $display("start id=%0d grant=%b p_in=%h cycle=%0d", CUR_ID, GRANT, P_IN, cyc);
            chk("start_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("grant", 64'(GRANT), 64'(1 << e.id));
                chk("cur_id", 64'(CUR_ID), 64'(e.id));
                chk("p_in", 64'(P_IN), 64'(e.data));
                if (e.abs_cyc >= 0) chk("latency", 64'(cyc), 64'(e.abs_cyc));
                if (e.spacing >= 0 && last_start >= 0) chk("spacing", 64'(cyc - last_start), 64'(e.spacing));
            end
            last_start = cyc;
        end
        if (RESET && FRAME_DONE) begin
            fd_seen++;
            chk("frame_done_delay", 64'(cyc - last_start), 64'(W));
        end
        if (GRANT != '0 && !S_START) chk("grant_outside_load", 64'(GRANT), 64'd0);
    end

    // Monitor for the GAP=0 instance.
    int last2 = -1;
    int low_run = 0;
    always @(negedge CLK) begin
        if (RESET && S_START2) begin
            $display("gap0 start id=%0d grant=%b p_in=%h cycle=%0d", CUR_ID2, GRANT2, P_IN2, cyc);
            chk("gap0_grant", 64'(GRANT2), 64'd1);
            chk("gap0_p_in", 64'(P_IN2), 64'h0000_0000_C3C3_3C3C);
            if (last2 >= 0) chk("gap0_spacing", 64'(cyc - last2), 64'd34);
            last2 = cyc;
        end
        if (REQ2 != '0 && last2 >= 0) begin
            if (!BUSY2) low_run++;
            else begin
                if (low_run > 0) chk("gap0_busy_low", 64'(low_run), 64'd1);
                low_run = 0;
            end
        end
    end

    task automatic wait_start(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (S_START) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL start_timeout: no S_START within %0d cycles", budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (!BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: BUSY still high after %0d cycles", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        // Reset state and quiet idle.
        repeat (3) @(negedge CLK);
        chk("rst_outputs", 64'({GRANT, S_START, P_IN, BUSY, CUR_ID, FRAME_DONE}), 64'd0);
        RESET = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("idle_quiet", 64'({S_START, GRANT, BUSY, FRAME_DONE}), 64'd0);
        end
        chk("idle_p_in", 64'(P_IN), 64'd0);

        // Single request from requester 0: latency, frame length, gap.
        DATA[0 +: W] = 32'hA5A5_0F0F;
        REQ = 4'b0001;
        exp_q.push_back('{0, 32'hA5A5_0F0F, cyc + 1, -1});
        wait_start(5, s);
        REQ = '0;
        repeat (33) @(negedge CLK);
        chk("busy_gap1", 64'(BUSY), 64'd1);
        @(negedge CLK);
        chk("busy_gap2", 64'(BUSY), 64'd1);
        @(negedge CLK);
        chk("busy_after_gap", 64'(BUSY), 64'd0);
        fd_exp += 1;
        chk("frame_done_count", 64'(fd_seen), 64'(fd_exp));

        // All requesters held after reset: order 0,1,2,3,0 every 36 cycles.
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < N; i++) DATA[i*W +: W] = 32'(i + 1);
        REQ = 4'b1111;
        exp_q.push_back('{0, 32'd1, cyc + 1, -1});
        exp_q.push_back('{1, 32'd2, -1, 36});
        exp_q.push_back('{2, 32'd3, -1, 36});
        exp_q.push_back('{3, 32'd4, -1, 36});
        exp_q.push_back('{0, 32'd1, -1, 36});
        for (int i = 0; i < 5; i++) wait_start(40, s);
        REQ = '0;
        wait_idle(50);
        fd_exp += 5;
        chk("frame_done_count", 64'(fd_seen), 64'(fd_exp));

        // Requests arriving mid-frame of requester 2 wait for frame + gap.
        for (int i = 0; i < N; i++) DATA[i*W +: W] = 32'h1000_0000 + 32'(i);
        REQ = 4'b0100;
        exp_q.push_back('{2, 32'h1000_0002, cyc + 1, -1});
        wait_start(5, s);
        REQ = '0;
        repeat (10) @(negedge CLK);
        REQ = 4'b1010;
        exp_q.push_back('{3, 32'h1000_0003, s + 36, 36});
        exp_q.push_back('{1, 32'h1000_0001, s + 72, 36});
        wait_start(40, s);
        REQ = 4'b0010;
        wait_start(40, s);
        REQ = '0;
        DATA[1*W +: W] = 32'hDEAD_BEEF;
        wait_idle(50);
        chk("p_in_hold", 64'(P_IN), 64'h0000_0000_1000_0001);
        fd_exp += 3;
        chk("frame_done_count", 64'(fd_seen), 64'(fd_exp));

        // Reset in the tenth SHIFT cycle aborts the frame.
        DATA[0 +: W] = 32'h0123_4567;
        REQ = 4'b0001;
        exp_q.push_back('{0, 32'h0123_4567, cyc + 1, -1});
        wait_start(5, s);
        REQ = '0;
        repeat (10) @(negedge CLK);
        #2 RESET = 1'b0;
        #1 chk("rst_async", 64'({GRANT, S_START, P_IN, BUSY, CUR_ID, FRAME_DONE}), 64'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            chk("rst_hold_quiet", 64'({FRAME_DONE, BUSY, S_START}), 64'd0);
        end
        chk("frame_done_count_abort", 64'(fd_seen), 64'(fd_exp));
        DATA[1*W +: W] = 32'h0BAD_F00D;
        REQ = 4'b1010;
        @(negedge CLK);
        RESET = 1'b1;
        exp_q.push_back('{1, 32'h0BAD_F00D, cyc + 1, -1});
        wait_start(5, s);
        REQ = '0;
        wait_idle(50);
        fd_exp += 1;
        chk("frame_done_count", 64'(fd_seen), 64'(fd_exp));

        // GAP=0 instance: requester 0 held, 34-cycle period.
        DATA2[0 +: W] = 32'hC3C3_3C3C;
        REQ2 = 4'b0001;
        begin
            int starts;
            starts = 0;
            for (int i = 0; i < 200 && starts < 4; i++) begin
                @(negedge CLK);
                if (S_START2) starts++;
            end
            REQ2 = '0;
            chk("gap0_start_count", 64'(starts), 64'd4);
        end
        repeat (40) @(negedge CLK);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/converter_tx_scheduler.md
Name: converter_tx_scheduler

Overview:
- Shares one parallel-to-serial transmitter (S_START / P_IN / S_OUT channel of the serial/parallel converter) among N requesters.
- Round-robin arbitration, word loading, one-cycle S_START generation, frame-length timing and an inter-frame guard gap.
- Sits between client logic and the converter top; the converter's S_START and P_IN are driven only by this block.

Parameters:
- N, 4, number of requesters (2..8).
- WIDTH, 32, serial word length in bits; equals the converter's P_IN width.
- GAP, 2, idle cycles enforced after each frame (0..15; 0 means no gap state).

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- REQ  input  N  per-requester transmit request, level, held until GRANT.
- DATA  input  N*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH].
- GRANT  output  N  one-hot, one-cycle pulse: word of requester i loaded.
- S_START  output  1  one-cycle load strobe to the converter.
- P_IN  output  WIDTH  registered word to the converter, stable from S_START until the next load.
- BUSY  output  1  high in LOAD, SHIFT and GAP.
- CUR_ID  output  clog2(N)  index of the last granted requester.
- FRAME_DONE  output  1  one-cycle pulse on the last SHIFT cycle.

Behaviour:
- Serializer contract: the converter samples P_IN on the edge where S_START=1 and drives the WIDTH bits on S_OUT during the next WIDTH cycles. The scheduler never pulses S_START while a frame is in flight.
- Reset (RESET=0, asynchronous):
  - state=IDLE; all outputs 0, including GRANT, S_START, P_IN, BUSY, CUR_ID and FRAME_DONE.
  - Round-robin pointer = N-1, so requester 0 has first priority.
  - Counter = 0.
  - Reset mid-frame aborts the frame with no FRAME_DONE.
- FSM states:
  - IDLE: if any REQ bit is set, select the first set bit searching from ptr+1 upward with wrap. On the next edge, register P_IN=DATA[sel], set CUR_ID=sel and ptr=sel, and go to LOAD. If no REQ bit is set, stay in IDLE.
  - LOAD (1 cycle): S_START=1 and GRANT[sel]=1. The counter is loaded with WIDTH-1. Next state is SHIFT.
  - SHIFT (WIDTH cycles): the counter decrements each cycle. At counter=0, FRAME_DONE=1 and the FSM goes to GAP, or to IDLE when GAP=0.
  - GAP (GAP cycles): counts down, then goes to IDLE.
- Latency and timing:
  - REQ seen in IDLE at edge c gives S_START/GRANT during cycle c+1.
  - Back-to-back start-to-start period is WIDTH+GAP+2 cycles (36 at defaults).
- REQ changes:
  - REQ changes outside IDLE are ignored until IDLE.
  - A requester that drops REQ before its grant is simply skipped.
  - DATA is sampled only at the IDLE→LOAD edge; later DATA changes do not affect P_IN.
- Fairness: a requester that holds REQ continuously waits at most N-1 frames.
- GRANT is asserted only in LOAD and carries exactly one hot bit.
- Simultaneous REQ from all requesters with ptr=N-1 grants order 0,1,…,N-1,0.
- P_IN holds its last value in IDLE; it is not cleared after a frame.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, GAP=2'd3.
  - Default WIDTH=32.
  - Counter width constant clog2(WIDTH).
- Sub-module rr_arbiter:
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt, index, any.
  - Purely combinational; reused by later multi-client blocks.
- FSM, counter, ptr and P_IN register live in converter_tx_scheduler.

Test Plan:
- Reset release, REQ=0 for 20 cycles → S_START, GRANT, BUSY and FRAME_DONE stay 0; P_IN=0.
- REQ=4'b0001, DATA0=32'hA5A5_0F0F → S_START and GRANT=0001 one cycle later; P_IN=A5A50F0F. The serial/parallel converter in loopback then gives P_OUT=A5A50F0F with P_VALID. FRAME_DONE comes 32 cycles after S_START; BUSY drops after 2 gap cycles.
- REQ=4'b1111 held, DATAi=i+1 → grant order 0,1,2,3,0. S_START spacing is exactly 36 cycles; P_IN sequence is 1,2,3,4,1.
- REQ1 asserted mid-frame of requester 2 → no S_START until the current frame plus gap completes; the next grant goes to 3 if REQ3 is set, else wraps to 1.
- RESET low at cycle 10 of SHIFT → all outputs 0 immediately with no FRAME_DONE. After release with REQ=4'b1010, the first grant is requester 1.
- GAP=0 build, REQ0 held → start-to-start period is 34 cycles and BUSY never drops for more than 1 cycle.
